// File: rtl/config_pkg.sv
// Shared opcodes, header size and controller state encoding for the ALU command path.
package config_pkg;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hAD,
    OP_MUL  = 8'h88
  } alu_op_e;

  localparam int HDR_BYTES = 4;

  typedef enum logic [3:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_DRAIN,
    S_ECHO,
    S_OPERAND,
    S_MUL,
    S_TX_RESULT
  } ctrl_state_e;

  // Byte idx of a 32-bit word, LSB first.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    b = w[7:0];
    case (idx)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier keeping the low OPERAND_WIDTH product bits.
// Operands are captured on start; done pulses OPERAND_WIDTH+1 cycles after the start cycle.
module alu_mul_seq #(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start,
  input  logic [OPERAND_WIDTH-1:0] a,
  input  logic [OPERAND_WIDTH-1:0] b,
  output logic                     done,
  output logic [OPERAND_WIDTH-1:0] product
);

  localparam int CW = $clog2(OPERAND_WIDTH + 1);

  logic [OPERAND_WIDTH-1:0] a_q;
  logic [OPERAND_WIDTH-1:0] b_q;
  logic [OPERAND_WIDTH-1:0] prod_q;
  logic [CW-1:0]            cnt_q;
  logic                     done_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q    <= a;
        b_q    <= b;
        prod_q <= '0;
        cnt_q  <= CW'(OPERAND_WIDTH);
      end else if (cnt_q != '0) begin
        // Bits shifted out of a_q only affect product bits above the kept width.
        if (b_q[0]) prod_q <= prod_q + a_q;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) done_q <= 1'b1;
      end
    end
  end

  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Packet sequencer between UART RX and TX: parses header, runs ECHO/ADD32/MUL32, streams result.
//
// state       | meaning
// S_OPCODE    | idle, waiting for opcode byte
// S_RSVD      | skip reserved header byte
// S_LEN_LO    | capture low LEN byte
// S_LEN_HI    | capture high LEN byte, validate and dispatch
// S_DRAIN     | discard payload of a rejected packet
// S_ECHO      | pass payload bytes through the output register
// S_OPERAND   | gather operand bytes LSB-first, accumulate
// S_MUL       | wait for the sequential multiplier
// S_TX_RESULT | send the accumulator, LSB first
module alu_cmd_ctrl
  import config_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  ctrl_state_e                         state_q;
  logic [DATA_WIDTH-1:0]               opcode_q;
  logic [DATA_WIDTH-1:0]               len_lo_q;
  logic [15:0]                         rem_q;
  logic [1:0]                          byte_cnt_q;
  logic [OPERAND_WIDTH-DATA_WIDTH-1:0] word_q;
  logic [OPERAND_WIDTH-1:0]            acc_q;
  logic                                first_word_q;
  logic                                last_word_q;
  logic                                rx_ready_q;
  logic                                tx_valid_q;
  logic [DATA_WIDTH-1:0]               tx_data_q;
  logic                                err_q;

  logic                     rx_fire;
  logic                     tx_fire;
  logic [15:0]              len;
  logic [15:0]              payload;
  logic [OPERAND_WIDTH-1:0] word_full;
  logic                     is_echo;
  logic                     is_add;
  logic                     is_mul;
  logic                     mul_start;
  logic                     mul_done;
  logic [OPERAND_WIDTH-1:0] mul_product;

  // In ECHO the single output register may be refilled in the same cycle it drains.
  assign rx_ready_o = (state_q == S_ECHO) ? (rx_ready_q && (!tx_valid_q || tx_ready_i))
                                          : rx_ready_q;
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign tx_fire    = tx_valid_q && tx_ready_i;

  assign len       = {rx_data_i, len_lo_q};
  assign payload   = len - 16'(HDR_BYTES);
  assign word_full = {rx_data_i, word_q};

  assign is_echo = (opcode_q == OP_ECHO);
  assign is_add  = (opcode_q == OP_ADD);
  assign is_mul  = (opcode_q == OP_MUL);

  assign mul_start = (state_q == S_OPERAND) && rx_fire && (byte_cnt_q == 2'd3)
                     && is_mul && !first_word_q;

  alu_mul_seq #(
    .OPERAND_WIDTH(OPERAND_WIDTH)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start  (mul_start),
    .a      (acc_q),
    .b      (word_full),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_OPCODE;
      opcode_q     <= '0;
      len_lo_q     <= '0;
      rem_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      acc_q        <= '0;
      first_word_q <= 1'b0;
      last_word_q  <= 1'b0;
      rx_ready_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_OPCODE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            opcode_q <= rx_data_i;
            state_q  <= S_RSVD;
          end
        end

        S_RSVD: begin
          if (rx_fire) state_q <= S_LEN_LO;
        end

        S_LEN_LO: begin
          if (rx_fire) begin
            len_lo_q <= rx_data_i;
            state_q  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (rx_fire) begin
            acc_q        <= '0;
            byte_cnt_q   <= '0;
            first_word_q <= 1'b1;
            rem_q        <= (len < 16'(HDR_BYTES)) ? 16'd0 : payload;
            if (len < 16'(HDR_BYTES)) begin
              err_q   <= 1'b1;
              state_q <= S_OPCODE;
            end else if (!(is_echo || is_add || is_mul)) begin
              err_q   <= 1'b1;
              state_q <= (payload == 16'd0) ? S_OPCODE : S_DRAIN;
            end else if (is_echo) begin
              state_q <= (payload == 16'd0) ? S_OPCODE : S_ECHO;
            end else if ((payload == 16'd0) || (payload[1:0] != 2'd0)) begin
              err_q   <= 1'b1;
              state_q <= (payload == 16'd0) ? S_OPCODE : S_DRAIN;
            end else begin
              state_q <= S_OPERAND;
            end
          end
        end

        S_DRAIN: begin
          if (rx_fire) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) state_q <= S_OPCODE;
          end
        end

        S_ECHO: begin
          if (rx_fire) begin
            tx_data_q  <= rx_data_i;
            tx_valid_q <= 1'b1;
            rem_q      <= rem_q - 16'd1;
            if (rem_q == 16'd1) rx_ready_q <= 1'b0;
          end else if (tx_fire) begin
            tx_valid_q <= 1'b0;
            if (!rx_ready_q) begin
              state_q    <= S_OPCODE;
              rx_ready_q <= 1'b1;
            end
          end
        end

        S_OPERAND: begin
          if (rx_fire) begin
            word_q     <= word_full[OPERAND_WIDTH-1:DATA_WIDTH];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            rem_q      <= rem_q - 16'd1;
            if (byte_cnt_q == 2'd3) begin
              first_word_q <= 1'b0;
              if (is_add) acc_q <= acc_q + word_full;
              else if (first_word_q) acc_q <= word_full;
              if (is_mul && !first_word_q) begin
                state_q     <= S_MUL;
                rx_ready_q  <= 1'b0;
                last_word_q <= (rem_q == 16'd1);
              end else if (rem_q == 16'd1) begin
                state_q    <= S_TX_RESULT;
                rx_ready_q <= 1'b0;
              end
            end
          end
        end

        S_MUL: begin
          if (mul_done) begin
            acc_q <= mul_product;
            if (last_word_q) begin
              state_q <= S_TX_RESULT;
            end else begin
              state_q    <= S_OPERAND;
              rx_ready_q <= 1'b1;
            end
          end
        end

        S_TX_RESULT: begin
          // byte_cnt_q is the index of the next byte to load; wrap to 0 means all four sent.
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= word_byte(acc_q, byte_cnt_q);
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end else if (tx_ready_i) begin
            if (byte_cnt_q == 2'd0) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_OPCODE;
              rx_ready_q <= 1'b1;
            end else begin
              tx_data_q  <= word_byte(acc_q, byte_cnt_q);
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end

        default: state_q <= S_OPCODE;
      endcase
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != S_OPCODE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: packet vector table with a tx byte scoreboard plus timing/reset sequences.
module tb_alu_cmd_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i = 1'b1;
  logic       busy_o;
  logic       err_o;

  alu_cmd_ctrl #(.DATA_WIDTH(8), .OPERAND_WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int         total = 0;
  int         bad = 0;
  int         err_seen = 0;
  int         rdy_mode = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [127:0] in_bytes;
    int           n_in;
    logic [63:0]  exp_bytes;
    int           n_exp;
    int           n_err;
    int           mode;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [127:0] ib, input int ni, input logic [63:0] eb,
                              input int ne, input int nerr, input int md);
    vec_t v;
    v.in_bytes  = ib;
    v.n_in      = ni;
    v.exp_bytes = eb;
    v.n_exp     = ne;
    v.n_err     = nerr;
    v.mode      = md;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("rx_accept_timeout", n, 0);
    @(posedge clk_i);
    #1 rx_valid_i = 1'b0;
  endtask

  task automatic monitor();
    logic       stalled;
    logic [7:0] held;
    logic [7:0] e;
    stalled = 1'b0;
    held    = 8'h00;
    forever begin
      @(negedge clk_i);
      if (err_o) err_seen++;
      if (stalled) begin
        check("tx_hold_valid", 32'(tx_valid_o), 1);
        check("tx_hold_data", 32'(tx_data_o), 32'(held));
      end
      stalled = 1'b0;
      if (tx_valid_o) begin
        if (tx_ready_i) begin
          if (exp_q.size() == 0) begin
            check("tx_unexpected_byte", 32'(tx_data_o) | 32'h100, 0);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(tx_data_o), 32'(e));
          end
        end else begin
          stalled = 1'b1;
          held    = tx_data_o;
        end
      end
    end
  endtask

  task automatic drive_ready();
    int t;
    t = 0;
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = 1'($urandom_range(0, 1));
        default: begin
          tx_ready_i = ~t[0];
          t++;
        end
      endcase
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_reached", 32'(n < 600), 1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic run_vec(input int i);
    int e0;
    rdy_mode = vecs[i].mode;
    for (int k = 0; k < vecs[i].n_exp; k++)
      exp_q.push_back(vecs[i].exp_bytes[8*(vecs[i].n_exp-1-k) +: 8]);
    e0 = err_seen;
    for (int k = 0; k < vecs[i].n_in; k++)
      send_byte(vecs[i].in_bytes[8*(vecs[i].n_in-1-k) +: 8]);
    wait_idle();
    check($sformatf("v%0d_err_count", i), err_seen - e0, vecs[i].n_err);
    check($sformatf("v%0d_busy_idle", i), 32'(busy_o), 0);
    rdy_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    int e0;

    // packet bytes written in wire order; operands appear LSB first
    vecs[0]  = mk(128'hAD000C00_01000000_FFFFFFFF, 12, 64'h00000000, 4, 0, 1);
    vecs[1]  = mk(128'h88000C00_03000100_05000000, 12, 64'h0F000500, 4, 0, 0);
    vecs[2]  = mk(128'hEC000700_414243, 7, 64'h414243, 3, 0, 2);
    vecs[3]  = mk(128'hAD000600_1122, 6, 64'h0, 0, 1, 0);
    vecs[4]  = mk(128'h55000500_99, 5, 64'h0, 0, 1, 0);
    vecs[5]  = mk(128'hAD001000_10000000_20000000_30000000, 16, 64'h60000000, 4, 0, 1);
    vecs[6]  = mk(128'hAD000200, 4, 64'h0, 0, 1, 0);
    vecs[7]  = mk(128'hAD000800_78563412, 8, 64'h78563412, 4, 0, 0);
    vecs[8]  = mk(128'h88000C00_00000100_00000100, 12, 64'h00000000, 4, 0, 1);
    vecs[9]  = mk(128'hEC000400, 4, 64'h0, 0, 0, 0);
    vecs[10] = mk(128'h88000800_EFBEADDE, 8, 64'hEFBEADDE, 4, 0, 1);
    vecs[11] = mk(128'h88001000_FFFFFFFF_FFFFFFFF_03000000, 16, 64'h03000000, 4, 0, 0);
    vecs[12] = mk(128'h12000400, 4, 64'h0, 0, 1, 0);

    repeat (3) @(negedge clk_i);
    check("rst_rx_ready", 32'(rx_ready_o), 0);
    check("rst_tx_valid", 32'(tx_valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_tx_data", 32'(tx_data_o), 0);
    rst_ni = 1'b1;

    fork
      monitor();
      drive_ready();
    join_none

    for (int i = 0; i < NV; i++) run_vec(i);

    // result appears on tx the cycle after entering S_TX_RESULT
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    send_byte(8'hAD); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    @(negedge clk_i);
    check("tx_first_not_early", 32'(tx_valid_o), 0);
    @(negedge clk_i);
    check("tx_first_cycle", 32'(tx_valid_o), 1);
    wait_idle();

    // rx stalled for the multiplier latency between words: 2*3*4 = 24
    exp_q.push_back(8'h18); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_byte(8'h88); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    lo = 0;
    @(negedge clk_i);
    while (!rx_ready_o && lo < 100) begin
      lo++;
      @(negedge clk_i);
    end
    check("mul_stall_cycles", lo, 33);
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_idle();

    // reset while multiplying abandons the packet
    e0 = err_seen;
    send_byte(8'h88); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (5) @(negedge clk_i);
    check("mid_mul_busy", 32'(busy_o), 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("mid_rst_tx_valid", 32'(tx_valid_o), 0);
    check("mid_rst_rx_ready", 32'(rx_ready_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    check("mid_rst_no_tx", 32'(tx_valid_o), 0);
    check("mid_rst_no_err", err_seen - e0, 0);

    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    send_byte(8'hEC); send_byte(8'h00); send_byte(8'h06); send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'hA5);
    wait_idle();

    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
